prim_subreg_shadow_bank: RTL and testbench



---
 rtl/prim_shadow_pkg.sv | 40 ++++
 rtl/prim_shadow_slot.sv | 75 +++++++
 rtl/prim_subreg_shadow_bank.sv | 116 +++++++++++
 tb/tb_prim_subreg_shadow_bank.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_shadow_pkg.sv
// Shared types and helpers for the shadowed CSR bank.
// Build option SHADOW_BANK_FATAL_LOCK_EN adds a sticky write lock on the first storage error.
package prim_shadow_pkg;

  typedef enum logic [2:0] {
    SwRW,
    SwWO,
    SwW1S,
    SwW1C,
    SwRO
  } swaccess_e;

  typedef struct packed {
    logic en;
    logic use_sw;
  } wr_sel_t;

  function automatic swaccess_e swaccess_from_str(input string s);
    if (s == "WO")  return SwWO;
    if (s == "W1S") return SwW1S;
    if (s == "W1C") return SwW1C;
    if (s == "RO")  return SwRO;
    return SwRW;
  endfunction

  // SW has priority over HW when both target a slot; RO slots only accept HW.
  function automatic wr_sel_t arb_write(input swaccess_e acc, input logic sw_we,
                                        input logic hw_de);
    wr_sel_t sel;
    if (acc == SwRO) begin
      sel.en     = hw_de;
      sel.use_sw = 1'b0;
    end else begin
      sel.en     = sw_we | hw_de;
      sel.use_sw = sw_we;
    end
    return sel;
  endfunction

endpackage

// File: rtl/prim_shadow_slot.sv
// One shadowed CSR slot: staged/shadow/committed copies, two-phase write protocol,
// update-mismatch and storage-corruption detection.
module prim_shadow_slot
  import prim_shadow_pkg::*;
#(
  parameter swaccess_e       SWACCESS = SwRW,
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   RESVAL   = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sw_we,
  input  logic          sw_re,
  input  logic [DW-1:0] wd,
  input  logic          hw_de,
  input  logic [DW-1:0] d,
  input  logic          lock,
  output logic          qe,
  output logic [DW-1:0] q,
  output logic          phase,
  output logic          err_update,
  output logic          err_storage
);

  logic [DW-1:0] staged_q, shadow_q, committed_q;
  logic          phase_q;
  wr_sel_t       sel;
  logic [DW-1:0] src, wr_data;
  logic          wr_en, match, rd_clr;

  always_comb begin
    sel     = arb_write(SWACCESS, sw_we, hw_de);
    src     = sel.use_sw ? wd : d;
    wr_data = src;
    case (SWACCESS)
      SwW1S:   wr_data = committed_q | src;
      SwW1C:   wr_data = committed_q & ~src;
      default: wr_data = src;
    endcase
  end

  assign wr_en      = sel.en & ~lock;
  assign match      = (~staged_q == wr_data);
  assign qe         = wr_en & phase_q & match;
  assign err_update = wr_en & phase_q & ~match;
  assign rd_clr     = sw_re & (SWACCESS != SwRO) & ~lock;

  // A write always toggles the phase; a read only abandons a pending first write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      staged_q    <= ~RESVAL;
      shadow_q    <= ~RESVAL;
      committed_q <= RESVAL;
      phase_q     <= 1'b0;
    end else if (wr_en) begin
      if (!phase_q) begin
        staged_q <= ~wr_data;
        phase_q  <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        if (match) begin
          shadow_q    <= staged_q;
          committed_q <= wr_data;
        end
      end
    end else if (rd_clr) begin
      phase_q <= 1'b0;
    end
  end

  assign err_storage = (~shadow_q != committed_q);
  assign q           = committed_q;
  assign phase       = phase_q;

endmodule

// File: rtl/prim_subreg_shadow_bank.sv
// Bank of NREG shadowed CSR slots behind one SW port, with a saturating update-error counter.
// Define SHADOW_BANK_FATAL_LOCK_EN to add the sticky fatal_lock_o write lock.
module prim_subreg_shadow_bank
  import prim_shadow_pkg::*;
#(
  parameter int                        NREG     = 4,
  parameter int                        DW       = 32,
  parameter string                     SWACCESS = "RW",
  parameter logic [NREG-1:0][DW-1:0]   RESVAL   = '0,
  parameter int                        CNTW     = 8,
  localparam int                       AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               re,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      wd,
  input  logic [NREG-1:0]    de,
  input  logic [NREG*DW-1:0] d,
  output logic [NREG-1:0]    qe,
  output logic [NREG*DW-1:0] q,
  output logic [DW-1:0]      qs,
  output logic [NREG-1:0]    phase_o,
  output logic [NREG-1:0]    err_update,
  output logic [NREG-1:0]    err_storage,
  output logic [CNTW-1:0]    err_update_cnt
`ifdef SHADOW_BANK_FATAL_LOCK_EN
  ,
  output logic               fatal_lock_o
`endif
);

  localparam swaccess_e     Acc    = swaccess_from_str(SWACCESS);
  localparam int            SumW   = CNTW + $clog2(NREG + 1) + 1;
  localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

  logic [NREG-1:0] sw_we_vec, sw_re_vec;
  logic            lock;

  // Out-of-range addresses match no slot, so they neither write nor read anything.
  always_comb begin
    sw_we_vec = '0;
    sw_re_vec = '0;
    qs        = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == AW'(i)) begin
        sw_we_vec[i] = we;
        sw_re_vec[i] = re;
        qs           = q[i*DW +: DW];
      end
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : gen_slot
    prim_shadow_slot #(
      .SWACCESS (Acc),
      .DW       (DW),
      .RESVAL   (RESVAL[i])
    ) u_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .sw_we       (sw_we_vec[i]),
      .sw_re       (sw_re_vec[i]),
      .wd          (wd),
      .hw_de       (de[i]),
      .d           (d[i*DW +: DW]),
      .lock        (lock),
      .qe          (qe[i]),
      .q           (q[i*DW +: DW]),
      .phase       (phase_o[i]),
      .err_update  (err_update[i]),
      .err_storage (err_storage[i])
    );
  end

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SumW-1:0] cnt_sum;

  always_comb begin
    cnt_sum = SumW'(cnt_q);
    for (int i = 0; i < NREG; i++) begin
      cnt_sum = cnt_sum + SumW'(err_update[i]);
    end
    cnt_d = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_update_cnt = cnt_q;

`ifdef SHADOW_BANK_FATAL_LOCK_EN
  logic lock_q;

  // Sticky until reset: a corrupted copy means no further write can be trusted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
    end else if (|err_storage) begin
      lock_q <= 1'b1;
    end
  end

  assign lock         = lock_q;
  assign fatal_lock_o = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_prim_subreg_shadow_bank.sv
// Directed self-checking bench for prim_subreg_shadow_bank (RW bank plus a small W1S bank).
// Lock checks follow SHADOW_BANK_FATAL_LOCK_EN.
module tb_prim_subreg_shadow_bank;

  logic         clk_i = 1'b0;
  logic         rst_ni;

  // main bank: 4 x 32 RW, CNTW 8
  logic         re, we;
  logic [1:0]   addr;
  logic [31:0]  wd;
  logic [3:0]   de;
  logic [127:0] d;
  logic [3:0]   qe, phase_o, err_update, err_storage;
  logic [127:0] q;
  logic [31:0]  qs;
  logic [7:0]   cnt;
  logic         fatal_lock;

  // small bank: 3 x 8 W1S, CNTW 2
  logic         s_re, s_we;
  logic [1:0]   s_addr;
  logic [7:0]   s_wd;
  logic [2:0]   s_qe, s_phase, s_err_update, s_err_storage;
  logic [23:0]  s_q;
  logic [7:0]   s_qs;
  logic [1:0]   s_cnt;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [127:0] ResMain = {32'h0000_0030, 32'h2222_0002, 32'h1111_0001, 32'h0000_0100};

  always #5 clk_i = ~clk_i;

  prim_subreg_shadow_bank #(
    .NREG(4), .DW(32), .SWACCESS("RW"), .RESVAL(ResMain), .CNTW(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .re(re), .we(we), .addr(addr), .wd(wd),
    .de(de), .d(d), .qe(qe), .q(q), .qs(qs), .phase_o(phase_o),
    .err_update(err_update), .err_storage(err_storage), .err_update_cnt(cnt)
`ifdef SHADOW_BANK_FATAL_LOCK_EN
    , .fatal_lock_o(fatal_lock)
`endif
  );

`ifndef SHADOW_BANK_FATAL_LOCK_EN
  assign fatal_lock = 1'b0;
`endif

  logic s_fatal_lock;
  prim_subreg_shadow_bank #(
    .NREG(3), .DW(8), .SWACCESS("W1S"), .RESVAL('0), .CNTW(2)
  ) dut_small (
    .clk_i(clk_i), .rst_ni(rst_ni), .re(s_re), .we(s_we), .addr(s_addr), .wd(s_wd),
    .de(3'b000), .d(24'h0), .qe(s_qe), .q(s_q), .qs(s_qs), .phase_o(s_phase),
    .err_update(s_err_update), .err_storage(s_err_storage), .err_update_cnt(s_cnt)
`ifdef SHADOW_BANK_FATAL_LOCK_EN
    , .fatal_lock_o(s_fatal_lock)
`endif
  );

`ifndef SHADOW_BANK_FATAL_LOCK_EN
  assign s_fatal_lock = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idleInputs();
    re = 0; we = 0; addr = 0; wd = 0; de = 0; d = 0;
    s_re = 0; s_we = 0; s_addr = 0; s_wd = 0;
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] a,
                               input logic [31:0] data, input logic [3:0] dev,
                               input logic [127:0] dv);
    @(negedge clk_i);
    we = w; re = r; addr = a; wd = data; de = dev; d = dv;
    #1;
  endtask

  task automatic applySmall(input logic w, input logic r, input logic [1:0] a,
                            input logic [7:0] data);
    @(negedge clk_i);
    s_we = w; s_re = r; s_addr = a; s_wd = data;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
    idleInputs();
    #1;
  endtask

  initial begin
    logic [1:0] expCnt;
    idleInputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;

    checkOutput("reset_q",       q, ResMain);
    checkOutput("reset_phase",   phase_o, 4'b0000);
    checkOutput("reset_storage", err_storage, 4'b0000);
    checkOutput("reset_cnt",     cnt, 8'd0);
    checkOutput("reset_qs",      qs, 32'h0000_0100);
    checkOutput("reset_small_q", s_q, 24'h0);

    // slot 2: matching pair commits
    applyStimulus(1, 0, 2'd2, 32'hA5, 4'b0, 128'h0);
    checkOutput("s2_first_qe", qe, 4'b0000);
    stepClock();
    checkOutput("s2_first_phase", phase_o, 4'b0100);
    checkOutput("s2_first_q", q[64 +: 32], 32'h2222_0002);
    applyStimulus(1, 0, 2'd2, 32'hA5, 4'b0, 128'h0);
    checkOutput("s2_second_qe", qe, 4'b0100);
    checkOutput("s2_second_err", err_update, 4'b0000);
    stepClock();
    checkOutput("s2_commit_q", q[64 +: 32], 32'hA5);
    checkOutput("s2_commit_phase", phase_o, 4'b0000);
    applyStimulus(0, 1, 2'd2, 32'h0, 4'b0, 128'h0);
    checkOutput("s2_qs", qs, 32'hA5);
    stepClock();

    // slot 1: mismatched pair
    applyStimulus(1, 0, 2'd1, 32'h11, 4'b0, 128'h0);
    stepClock();
    applyStimulus(1, 0, 2'd1, 32'h22, 4'b0, 128'h0);
    checkOutput("s1_err_update", err_update, 4'b0010);
    checkOutput("s1_no_qe", qe, 4'b0000);
    stepClock();
    checkOutput("s1_err_clear", err_update, 4'b0000);
    checkOutput("s1_q_hold", q[32 +: 32], 32'h1111_0001);
    checkOutput("s1_cnt", cnt, 8'd1);
    checkOutput("s1_phase", phase_o, 4'b0000);

    // slot 0: read between writes restarts the protocol
    applyStimulus(1, 0, 2'd0, 32'h5, 4'b0, 128'h0);
    stepClock();
    checkOutput("s0_phase_set", phase_o, 4'b0001);
    applyStimulus(0, 1, 2'd0, 32'h0, 4'b0, 128'h0);
    stepClock();
    checkOutput("s0_read_clears", phase_o, 4'b0000);
    applyStimulus(1, 0, 2'd0, 32'h6, 4'b0, 128'h0);
    checkOutput("s0_no_err", err_update, 4'b0000);
    checkOutput("s0_no_qe", qe, 4'b0000);
    stepClock();
    checkOutput("s0_restaged", phase_o, 4'b0001);
    // write with a same-cycle read still commits
    applyStimulus(1, 1, 2'd0, 32'h6, 4'b0, 128'h0);
    checkOutput("s0_qe", qe, 4'b0001);
    stepClock();
    checkOutput("s0_q", q[0 +: 32], 32'h6);
    checkOutput("cnt_still_1", cnt, 8'd1);

    // SW vs HW on slot 0, concurrent HW on slot 1
    applyStimulus(1, 0, 2'd0, 32'h9, 4'b0, 128'h0);
    stepClock();
    applyStimulus(1, 0, 2'd0, 32'h9, 4'b0011, {64'h0, 32'h44, 32'hDEAD});
    checkOutput("arb_qe", qe, 4'b0001);
    checkOutput("arb_err", err_update, 4'b0000);
    stepClock();
    checkOutput("arb_q0", q[0 +: 32], 32'h9);
    checkOutput("arb_phase", phase_o, 4'b0010);
    applyStimulus(0, 0, 2'd0, 32'h0, 4'b0010, {64'h0, 32'h44, 32'h0});
    checkOutput("hw_qe", qe, 4'b0010);
    stepClock();
    checkOutput("hw_q1", q[32 +: 32], 32'h44);

    // storage fault on slot 3
    @(negedge clk_i);
    force dut.gen_slot[3].u_slot.committed_q = 32'h31;
    #1;
    checkOutput("s3_storage", err_storage, 4'b1000);
    checkOutput("s3_q_forced", q[96 +: 32], 32'h31);
    stepClock();
    release dut.gen_slot[3].u_slot.committed_q;
`ifdef SHADOW_BANK_FATAL_LOCK_EN
    checkOutput("lock_set", fatal_lock, 1'b1);
    applyStimulus(1, 0, 2'd3, 32'h7, 4'b0, 128'h0);
    stepClock();
    checkOutput("lock_phase", phase_o, 4'b0000);
    applyStimulus(1, 0, 2'd0, 32'h7, 4'b0, 128'h0);
    checkOutput("lock_no_qe", qe, 4'b0000);
    stepClock();
    checkOutput("lock_q0_hold", q[0 +: 32], 32'h9);
`else
    applyStimulus(1, 0, 2'd3, 32'h7, 4'b0, 128'h0);
    stepClock();
    applyStimulus(1, 0, 2'd3, 32'h7, 4'b0, 128'h0);
    checkOutput("s3_qe", qe, 4'b1000);
    stepClock();
    checkOutput("s3_q", q[96 +: 32], 32'h7);
    checkOutput("s3_storage_clear", err_storage, 4'b0000);
`endif

    // small bank: counter saturation
    for (int k = 1; k <= 5; k++) begin
      applySmall(1, 0, 2'd0, 8'h01);
      stepClock();
      applySmall(1, 0, 2'd0, 8'h02);
      checkOutput("small_err", s_err_update, 3'b001);
      stepClock();
      expCnt = (k > 3) ? 2'd3 : 2'(k);
      checkOutput("small_cnt", s_cnt, expCnt);
    end

    // small bank: W1S accumulates
    applySmall(1, 0, 2'd0, 8'h01);
    stepClock();
    applySmall(1, 0, 2'd0, 8'h01);
    checkOutput("w1s_qe", s_qe, 3'b001);
    stepClock();
    checkOutput("w1s_q1", s_q, 24'h000001);
    applySmall(1, 0, 2'd0, 8'h02);
    stepClock();
    applySmall(1, 0, 2'd0, 8'h02);
    stepClock();
    checkOutput("w1s_q3", s_q, 24'h000003);

    // small bank: out-of-range address
    applySmall(1, 1, 2'd3, 8'hFF);
    checkOutput("oor_qs", s_qs, 8'h00);
    checkOutput("oor_qe", s_qe, 3'b000);
    stepClock();
    checkOutput("oor_phase", s_phase, 3'b000);
    checkOutput("oor_q", s_q, 24'h000003);

    // reset mid-protocol discards the staged value
    applyStimulus(1, 0, 2'd2, 32'h5A, 4'b0, 128'h0);
    stepClock();
    checkOutput("mid_phase", phase_o, 4'b0100);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    #1;
    checkOutput("mid_reset_phase", phase_o, 4'b0000);
    checkOutput("mid_reset_q", q, ResMain);
    checkOutput("mid_reset_lock", fatal_lock, 1'b0);
    applyStimulus(1, 0, 2'd2, 32'h5A, 4'b0, 128'h0);
    checkOutput("mid_no_qe", qe, 4'b0000);
    stepClock();
    checkOutput("mid_restaged", phase_o, 4'b0100);
    checkOutput("small_lock_idle", s_fatal_lock, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
